instruction_decode: RTL and testbench

Second stage of the 5-stage MIPS pipeline: consumes the instruction and incremented PC held in the IF/ID register and produces the registered ID/EX pipeline register. Contains the 32×32 register file written by WB, the main control decoder, sign extension and load-use hazard detection. Drives `stall` back to fetch and IF/ID to hold them for one cycle on a load-use hazard.

---
 rtl/instruction_decode_pkg.sv | 77 +++++++
 rtl/instruction_decode_register_file.sv | 46 ++++
 rtl/instruction_decode.sv | 108 ++++++++++
 tb/tb_instruction_decode.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared MIPS decode definitions: opcodes,
// ALU classes, control bundle and decoder.
package mips_defs;

  localparam int REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } id_ex_t;

  function automatic ctrl_t decode(
    input logic [5:0] op
  );
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file, one write port,
// two combinational read ports with WB bypass.
module register_file
  import mips_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [REG_W-1:0] raddr1,
  input  logic [REG_W-1:0] raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = we && (waddr != '0);

  // register array: cleared on reset, else WB write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // read ports: r0 is zero, same-cycle WB wins
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (raddr1 == '0)
      rdata1 = '0;
    else if (wr_en && waddr == raddr1)
      rdata1 = wdata;
    if (raddr2 == '0)
      rdata2 = '0;
    else if (wr_en && waddr == raddr2)
      rdata2 = wdata;
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode, register read, sign
// extension, load-use stall and ID/EX register.
module instruction_decode
  import mips_defs::*;
#(
  parameter int B = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [B-1:0]     pc_incrementado,
  input  logic             flush,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_write_reg,
  input  logic [31:0]      wb_write_data,
  output logic             stall,
  output logic [B-1:0]     id_ex_pc_incrementado,
  output logic [31:0]      id_ex_read_data1,
  output logic [31:0]      id_ex_read_data2,
  output logic [31:0]      id_ex_sign_ext_imm,
  output logic [REG_W-1:0] id_ex_rs,
  output logic [REG_W-1:0] id_ex_rt,
  output logic [REG_W-1:0] id_ex_rd,
  output logic             id_ex_reg_dst,
  output logic             id_ex_alu_src,
  output logic             id_ex_mem_to_reg,
  output logic             id_ex_reg_write,
  output logic             id_ex_mem_read,
  output logic             id_ex_mem_write,
  output logic             id_ex_branch,
  output logic [1:0]       id_ex_alu_op
);

  logic [5:0]       op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [31:0]      rd1;
  logic [31:0]      rd2;
  logic [31:0]      imm;
  ctrl_t            ctrl;
  id_ex_t           q;
  logic [B-1:0]     pc_q;

  assign op   = instruction[31:26];
  assign rs   = instruction[25:21];
  assign rt   = instruction[20:16];
  assign rd   = instruction[15:11];
  assign imm  = {{16{instruction[15]}},
                 instruction[15:0]};
  assign ctrl = decode(op);

  register_file u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // load in EX whose target feeds this instruction
  always_comb begin
    stall = q.ctrl.mem_read
         && (q.rt != '0)
         && (q.rt == rs || q.rt == rt);
  end

  // ID/EX register: reset, else bubble or decode
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      pc_q <= '0;
    end else begin
      pc_q  <= pc_incrementado;
      q.rd1 <= rd1;
      q.rd2 <= rd2;
      q.imm <= imm;
      q.rs  <= rs;
      q.rt  <= rt;
      q.rd  <= rd;
      if (flush || stall)
        q.ctrl <= '0;
      else
        q.ctrl <= ctrl;
    end
  end

  assign id_ex_pc_incrementado = pc_q;
  assign id_ex_read_data1      = q.rd1;
  assign id_ex_read_data2      = q.rd2;
  assign id_ex_sign_ext_imm    = q.imm;
  assign id_ex_rs              = q.rs;
  assign id_ex_rt              = q.rt;
  assign id_ex_rd              = q.rd;
  assign id_ex_reg_dst         = q.ctrl.reg_dst;
  assign id_ex_alu_src         = q.ctrl.alu_src;
  assign id_ex_mem_to_reg      = q.ctrl.mem_to_reg;
  assign id_ex_reg_write       = q.ctrl.reg_write;
  assign id_ex_mem_read        = q.ctrl.mem_read;
  assign id_ex_mem_write       = q.ctrl.mem_write;
  assign id_ex_branch          = q.ctrl.branch;
  assign id_ex_alu_op          = q.ctrl.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed plan
// plus random traffic against a cycle model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] pc_incrementado = '0;
  logic        flush = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_write_reg = '0;
  logic [31:0] wb_write_data = '0;
  logic        stall;
  logic [31:0] o_pc, o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_reg_dst, o_alu_src, o_m2r;
  logic        o_reg_write, o_mem_read;
  logic        o_mem_write, o_branch;
  logic [1:0]  o_alu_op;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  instruction_decode #(.B(32)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .instruction           (instruction),
    .pc_incrementado       (pc_incrementado),
    .flush                 (flush),
    .wb_reg_write          (wb_reg_write),
    .wb_write_reg          (wb_write_reg),
    .wb_write_data         (wb_write_data),
    .stall                 (stall),
    .id_ex_pc_incrementado (o_pc),
    .id_ex_read_data1      (o_rd1),
    .id_ex_read_data2      (o_rd2),
    .id_ex_sign_ext_imm    (o_imm),
    .id_ex_rs              (o_rs),
    .id_ex_rt              (o_rt),
    .id_ex_rd              (o_rd),
    .id_ex_reg_dst         (o_reg_dst),
    .id_ex_alu_src         (o_alu_src),
    .id_ex_mem_to_reg      (o_m2r),
    .id_ex_reg_write       (o_reg_write),
    .id_ex_mem_read        (o_mem_read),
    .id_ex_mem_write       (o_mem_write),
    .id_ex_branch          (o_branch),
    .id_ex_alu_op          (o_alu_op)
  );

  // ---------------- reference model ----------------
  logic [31:0] mr [32];
  logic [8:0]  e_ctrl = '0;
  logic [31:0] e_pc = '0, e_rd1 = '0;
  logic [31:0] e_rd2 = '0, e_imm = '0;
  logic [4:0]  e_rs = '0, e_rt = '0, e_rd = '0;
  bit          e_dvalid = 1;
  bit          m_held = 0;

  // {reg_dst,alu_src,mem_to_reg,reg_write,
  //  mem_read,mem_write,branch,alu_op}
  function automatic logic [8:0] ctl_of(
    input logic [5:0] op
  );
    case (op)
      6'h00:   return 9'b1_0_0_1_0_0_0_10;
      6'h23:   return 9'b0_1_1_1_1_0_0_00;
      6'h2b:   return 9'b0_1_0_0_0_1_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_1_0_0_0_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] rread(
    input logic [4:0] a
  );
    if (a == 0) return 0;
    if (wb_reg_write && wb_write_reg == a)
      return wb_write_data;
    return mr[a];
  endfunction

  function automatic bit m_stall();
    logic [4:0] rs, rt;
    rs = instruction[25:21];
    rt = instruction[20:16];
    return e_ctrl[4] && e_rt != 0
        && (e_rt == rs || e_rt == rt);
  endfunction

  initial for (int i = 0; i < 32; i++) mr[i] = 0;

  always @(posedge clk) begin
    bit st;
    st = m_stall();
    if (reset) begin
      for (int i = 0; i < 32; i++) mr[i] = 0;
      e_ctrl = 0; e_pc = 0; e_rd1 = 0;
      e_rd2 = 0; e_imm = 0; e_rs = 0;
      e_rt = 0; e_rd = 0;
      e_dvalid = 1;
      m_held = 0;
    end else begin
      e_ctrl = (flush || st) ? 9'b0
             : ctl_of(instruction[31:26]);
      e_dvalid = !(flush || st);
      e_pc  = pc_incrementado;
      e_rd1 = rread(instruction[25:21]);
      e_rd2 = rread(instruction[20:16]);
      e_imm = {{16{instruction[15]}},
               instruction[15:0]};
      e_rs = instruction[25:21];
      e_rt = instruction[20:16];
      e_rd = instruction[15:11];
      if (wb_reg_write && wb_write_reg != 0)
        mr[wb_write_reg] = wb_write_data;
      m_held = st && !flush;
    end
  end

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // compare process: outputs vs model, each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(stall), 32'(m_stall()));
      cmp("ctrl",
          {23'b0, o_reg_dst, o_alu_src, o_m2r,
           o_reg_write, o_mem_read, o_mem_write,
           o_branch, o_alu_op},
          {23'b0, e_ctrl});
      if (e_dvalid) begin
        cmp("pc", o_pc, e_pc);
        cmp("rd1", o_rd1, e_rd1);
        cmp("rd2", o_rd2, e_rd2);
        cmp("imm", o_imm, e_imm);
        cmp("rs", 32'(o_rs), 32'(e_rs));
        cmp("rt", 32'(o_rt), 32'(e_rt));
        cmp("rd", 32'(o_rd), 32'(e_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc_cnt = 32'h100;

  task automatic step(input logic [31:0] ins,
                      input bit fl,
                      input bit we,
                      input logic [4:0] wr,
                      input logic [31:0] wd,
                      input bit rst);
    @(posedge clk);
    #1;
    if (ins != instruction) pc_cnt += 4;
    instruction     = ins;
    pc_incrementado = pc_cnt;
    flush           = fl;
    wb_reg_write    = we;
    wb_write_reg    = wr;
    wb_write_data   = wd;
    reset           = rst;
    #1;
  endtask

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rins();
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2b;
      3: op = 6'h04;
      4: op = 6'h08;
      default: op = 6'($urandom);
    endcase
    return {op, rreg(), rreg(), 16'($urandom)};
  endfunction

  localparam logic [31:0] NOP = 32'hFC00_0000;

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    step(NOP, 0, 1, 5'd1, 32'h5, 0);
    step(NOP, 0, 1, 5'd2, 32'h7, 0);
    step(32'h00221820, 0, 0, 0, 0, 0);
    step(32'h2004FFFE, 0, 0, 0, 0, 0);
    cmp("lit_add_rd1", o_rd1, 32'h5);
    cmp("lit_add_rd2", o_rd2, 32'h7);
    cmp("lit_add_rd", 32'(o_rd), 32'd3);
    cmp("lit_add_ctl",
        {29'b0, o_reg_dst, o_reg_write, o_alu_src},
        32'b110);
    cmp("lit_add_aluop", 32'(o_alu_op), 32'd2);
    step(32'h8C250000, 0, 0, 0, 0, 0);
    cmp("lit_addi_imm", o_imm, 32'hFFFF_FFFE);
    cmp("lit_addi_src", 32'(o_alu_src), 32'd1);
    cmp("lit_addi_rw", 32'(o_reg_write), 32'd1);
    cmp("lit_addi_rd1", o_rd1, 32'h0);
    step(32'h00A13020, 0, 0, 0, 0, 0);
    cmp("lit_lu_stall", 32'(stall), 32'd1);
    step(32'h00A13020, 0, 0, 0, 0, 0);
    cmp("lit_bubble",
        {23'b0, o_reg_dst, o_alu_src, o_m2r,
         o_reg_write, o_mem_read, o_mem_write,
         o_branch, o_alu_op}, 32'h0);
    cmp("lit_unstall", 32'(stall), 32'd0);
    step(NOP, 0, 0, 0, 0, 0);
    cmp("lit_reissue_rs", 32'(o_rs), 32'd5);
    cmp("lit_reissue_rw", 32'(o_reg_write), 32'd1);
    step(32'h00095020, 0, 1, 5'd9, 32'h1234, 0);
    step(NOP, 0, 0, 0, 0, 0);
    cmp("lit_bypass", o_rd2, 32'h1234);
    step(32'h00005820, 0, 1, 5'd0, 32'hFFFF, 0);
    step(NOP, 0, 0, 0, 0, 0);
    cmp("lit_r0", o_rd1, 32'h0);
    step(32'hAC220004, 1, 1, 5'd7, 32'h77, 0);
    step(32'h00E06020, 0, 0, 0, 0, 0);
    cmp("lit_flush_mw", 32'(o_mem_write), 32'd0);
    cmp("lit_flush_src", 32'(o_alu_src), 32'd0);
    step(NOP, 0, 0, 0, 0, 0);
    cmp("lit_flush_wb", o_rd1, 32'h77);
    step(32'h8C250000, 0, 0, 0, 0, 0);
    step(32'h00A13020, 0, 0, 0, 0, 1);
    step(32'h00221820, 0, 0, 0, 0, 0);
    cmp("lit_rst_mr", 32'(o_mem_read), 32'd0);
    cmp("lit_rst_stall", 32'(stall), 32'd0);
    cmp("lit_rst_rt", 32'(o_rt), 32'd0);
    step(NOP, 0, 0, 0, 0, 0);
    cmp("lit_rst_r1", o_rd1, 32'h0);
    cmp("lit_rst_r2", o_rd2, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      bit fl, we, rs;
      fl = ($urandom_range(0, 9) == 0);
      we = $urandom_range(0, 1) == 1;
      rs = ($urandom_range(0, 99) < 2);
      ins = m_held ? instruction : rins();
      step(ins, fl, we, rreg(), $urandom, rs);
    end
    step(NOP, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
